led_rate_detector: RTL and testbench

LED_RATE_DETECTOR -- requirements
Module: led_rate_detector

---
 rtl/led_rate_detector.sv | 186 ++++++++++++++++++
 tb/tb_led_rate_detector.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_rate_detector.sv
// LED blink-rate classifier: measures level-run lengths of a synchronized LED input
// and locks to one of four nominal rates once two consecutive runs agree.
module led_rate_detector #(
    parameter int c_max_count_1Hz  = 25,
    parameter int c_max_count_5Hz  = 10,
    parameter int c_max_count_10Hz = 5,
    parameter int c_max_count_20Hz = 2,
    parameter int c_TOL            = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_led,
    output logic o_select0,
    output logic o_select1,
    output logic o_valid,
    output logic o_lost,
    output logic o_update
);
    localparam int c_sat   = c_max_count_1Hz + c_TOL + 1;
    localparam int c_cnt_w = $clog2(c_sat + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(c_sat);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_CAND,
        S_LOCKED
    } state_t;

    // NOTE: the internal reset asserts asynchronously but releases only after two
    // clock edges, so no flop leaves reset on a partial cycle.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic               led_meta_q, led_sync_q, led_prev_q;
    logic               led_edge;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               run_match;
    logic [1:0]         run_code;

    logic               ev_edge_q, ev_edge_d;
    logic               ev_timeout_q, ev_timeout_d;
    logic               ev_match_q, ev_match_d;
    logic [1:0]         ev_code_q, ev_code_d;

    state_t             state_q, state_d;
    logic [1:0]         cand_q, cand_d;
    logic [1:0]         sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               lost_q, lost_d;
    logic               update_q, update_d;

    assign led_edge = led_sync_q ^ led_prev_q;

    function automatic logic in_range(input logic [c_cnt_w-1:0] len, input int nominal);
        int len_i;
        len_i = int'(len);
        return (len_i >= nominal - c_TOL) && (len_i <= nominal + c_TOL);
    endfunction

    // Fastest rate wins when tolerance windows overlap.
    always_comb begin
        run_match = 1'b1;
        run_code  = 2'b00;
        if (in_range(cnt_q, c_max_count_20Hz)) begin
            run_code = 2'b11;
        end else if (in_range(cnt_q, c_max_count_10Hz)) begin
            run_code = 2'b10;
        end else if (in_range(cnt_q, c_max_count_5Hz)) begin
            run_code = 2'b01;
        end else if (!in_range(cnt_q, c_max_count_1Hz)) begin
            run_match = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (led_edge) begin
            cnt_d = c_cnt_one;
        end else if (cnt_q != c_cnt_sat) begin
            cnt_d = cnt_q + c_cnt_one;
        end
        ev_edge_d    = led_edge;
        ev_timeout_d = (cnt_q == c_cnt_sat) && !led_edge;
        ev_match_d   = led_edge && run_match;
        ev_code_d    = run_code;
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        lost_d  = lost_q;
        if (ev_edge_q) begin
            lost_d = 1'b0;
            unique case (state_q)
                S_IDLE: state_d = S_FIRST;
                S_FIRST: begin
                    if (ev_match_q) begin
                        state_d = S_CAND;
                        cand_d  = ev_code_q;
                    end
                end
                S_CAND: begin
                    if (!ev_match_q) begin
                        state_d = S_FIRST;
                    end else if (ev_code_q == cand_q) begin
                        state_d = S_LOCKED;
                        sel_d   = ev_code_q;
                        valid_d = 1'b1;
                    end else begin
                        cand_d = ev_code_q;
                    end
                end
                S_LOCKED: begin
                    if (!ev_match_q) begin
                        state_d = S_FIRST;
                        valid_d = 1'b0;
                    end else if (ev_code_q != sel_q) begin
                        state_d = S_CAND;
                        cand_d  = ev_code_q;
                        valid_d = 1'b0;
                    end
                end
            endcase
        end else if (ev_timeout_q && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            lost_d  = 1'b1;
        end
        update_d = (valid_d != valid_q) || (lost_d != lost_q) || (sel_d != sel_q);
    end

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            led_meta_q   <= 1'b0;
            led_sync_q   <= 1'b0;
            led_prev_q   <= 1'b0;
            cnt_q        <= c_cnt_one;
            ev_edge_q    <= 1'b0;
            ev_timeout_q <= 1'b0;
            ev_match_q   <= 1'b0;
            ev_code_q    <= 2'b00;
            state_q      <= S_IDLE;
            cand_q       <= 2'b00;
            sel_q        <= 2'b00;
            valid_q      <= 1'b0;
            lost_q       <= 1'b1;
            update_q     <= 1'b0;
        end else begin
            led_meta_q   <= i_led;
            led_sync_q   <= led_meta_q;
            led_prev_q   <= led_sync_q;
            cnt_q        <= cnt_d;
            ev_edge_q    <= ev_edge_d;
            ev_timeout_q <= ev_timeout_d;
            ev_match_q   <= ev_match_d;
            ev_code_q    <= ev_code_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            sel_q        <= sel_d;
            valid_q      <= valid_d;
            lost_q       <= lost_d;
            update_q     <= update_d;
        end
    end

    assign o_select0 = sel_q[0];
    assign o_select1 = sel_q[1];
    assign o_valid   = valid_q;
    assign o_lost    = lost_q;
    assign o_update  = update_q;

endmodule

// File: tb/tb_led_rate_detector.sv
// Bench for led_rate_detector: run-length reference model with a 3-clock output
// delay line, directed rate scenarios pinned by literals, then random runs.
module tb_led_rate_detector;
    localparam int c_sat = 27;
    localparam logic [4:0] c_rst_vec = 5'b00010;

    logic clk = 1'b0;
    logic rst_n;
    logic led;
    logic o_select0, o_select1, o_valid, o_lost, o_update;
    logic [4:0] dut_vec;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b1;

    int nom [4] = '{25, 10, 5, 2};

    // Model state: time of last accepted level change, code of the previous run.
    int         m_time, m_last, m_prev;
    bit         m_seen, m_valid, m_lost;
    logic       m_level;
    logic [1:0] m_code;
    logic [3:0] m_prev_vis;
    logic [4:0] m_pipe [$];
    logic [4:0] exp_cur;

    led_rate_detector dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_led     (led),
        .o_select0 (o_select0),
        .o_select1 (o_select1),
        .o_valid   (o_valid),
        .o_lost    (o_lost),
        .o_update  (o_update)
    );

    assign dut_vec = {o_select1, o_select0, o_valid, o_lost, o_update};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {sel,valid,lost,update}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input int run);
        for (int c = 3; c >= 0; c--) begin
            if (run >= nom[c] - 1 && run <= nom[c] + 1) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_seen     = 1'b0;
        m_prev     = -1;
        m_valid    = 1'b0;
        m_lost     = 1'b1;
        m_code     = 2'b00;
        m_level    = 1'b0;
        m_prev_vis = 4'b0001;
        m_pipe     = {c_rst_vec, c_rst_vec, c_rst_vec};
        exp_cur    = c_rst_vec;
    endtask

    task automatic model_step();
        logic [3:0] vis;
        int run, code;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_time++;
        if (led !== m_level) begin
            m_level = led;
            if (m_seen) begin
                run  = (m_time - m_last > c_sat) ? c_sat : m_time - m_last;
                code = classify(run);
                if (code < 0) begin
                    m_prev  = -1;
                    m_valid = 1'b0;
                end else if (code == m_prev) begin
                    m_valid = 1'b1;
                    m_code  = 2'(code);
                end else begin
                    m_prev  = code;
                    m_valid = 1'b0;
                end
            end else begin
                m_seen = 1'b1;
                m_prev = -1;
            end
            m_lost = 1'b0;
            m_last = m_time;
        end else if (m_seen && (m_time - m_last >= c_sat)) begin
            m_seen  = 1'b0;
            m_prev  = -1;
            m_valid = 1'b0;
            m_lost  = 1'b1;
        end
        vis = {m_code, m_valid, m_lost};
        m_pipe.push_back({vis, vis != m_prev_vis});
        m_prev_vis = vis;
        exp_cur = m_pipe.pop_front();
    endtask

    initial begin
        m_time = 0;
        m_last = 0;
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (cmp_en) check("model", dut_vec, rst_n ? exp_cur : c_rst_vec);
        end
    end

    task automatic toggle(input int len);
        led = ~led;
        repeat (len) @(negedge clk);
    endtask

    // Flip, then inspect outputs just after the third clock edge following the sample.
    task automatic toggle_probe(input int len, input string name, input logic [4:0] exp);
        led = ~led;
        repeat (4) @(posedge clk);
        #1 check(name, dut_vec, exp);
        repeat (len - 3) @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        led   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int cur_rate, len, sel;
        rst_n = 1'b1;
        led   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_state", dut_vec, c_rst_vec);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // 10-clock runs: lock to 01 three clocks after the third edge.
        toggle_probe(10, "first_edge_clears_lost", 5'b00001);
        toggle_probe(10, "candidate_10", 5'b00000);
        led = ~led;
        repeat (3) @(posedge clk);
        #1 check("lock_latency_before", dut_vec, 5'b00000);
        @(posedge clk);
        #1 check("lock_latency_at", dut_vec, 5'b01101);
        @(posedge clk);
        #1 check("update_single_pulse", dut_vec, 5'b01100);
        repeat (6) @(negedge clk);
        toggle(10);
        toggle(10);

        // 2-clock runs lock 11, then 25-clock runs drop and re-lock to 00.
        repeat (6) toggle(2);
        toggle_probe(25, "locked_11", 5'b11100);
        toggle_probe(25, "drop_on_first_25", 5'b11001);
        toggle_probe(25, "relock_00", 5'b00101);

        // 5-clock lock, one 8-clock invalid run, then recovery.
        repeat (3) toggle(5);
        toggle(8);
        toggle_probe(5, "invalid_8_run", 5'b10001);
        toggle_probe(5, "candidate_after_invalid", 5'b10000);
        toggle_probe(5, "relock_10", 5'b10101);

        // Tolerance edges 9/11 lock 01; a 12-clock run breaks it.
        toggle(9);
        toggle(11);
        toggle_probe(9, "lock_9_11", 5'b01101);
        toggle(11);
        toggle(12);
        toggle_probe(9, "break_on_12", 5'b01001);

        // Hold the LED until the run counter saturates.
        toggle(10);
        toggle_probe(10, "relock_01", 5'b01101);
        repeat (20) @(posedge clk);
        #1 check("pre_timeout", dut_vec, 5'b01100);
        @(posedge clk);
        #1 check("timeout_lost", dut_vec, 5'b01011);
        repeat (4) @(negedge clk);
        toggle_probe(10, "edge_clears_lost", 5'b01001);

        // Asynchronous reset while locked, then a normal re-lock.
        toggle(10);
        toggle(10);
        repeat (3) @(negedge clk);
        check("locked_before_reset", dut_vec, 5'b01100);
        rst_n = 1'b0;
        led   = 1'b0;
        #1 check("async_reset", dut_vec, c_rst_vec);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        toggle(10);
        toggle(10);
        toggle_probe(10, "relock_after_reset", 5'b01101);

        // Random runs biased towards a persistent rate, with noise, timeouts and resets.
        cur_rate = 0;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 0) cur_rate = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 19));
            if (sel < 13) begin
                len = nom[cur_rate] + int'($urandom_range(0, 2)) - 1;
                toggle(len);
            end else if (sel < 17) begin
                len = int'($urandom_range(1, 30));
                toggle(len);
            end else if (sel < 19) begin
                len = int'($urandom_range(26, 40));
                toggle(len);
            end else begin
                reset_pulse();
            end
        end

        repeat (40) @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
